// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package fetch_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int DEPTH_DEF = 2;

  // IDLE: free to issue; WAIT: one request outstanding;
  // DROP: the outstanding response was made stale by a flush and must be discarded.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  // Buffer entry at default width. The FIFO stores entries packed in this
  // same {pc, instr} order, so a default-width entry can be viewed as this struct.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular fetch buffer with synchronous flush and occupancy count.
// Flush wins over push and pop in the same cycle.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Next pointers and count; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    do_push  = push & ~full & ~flush;
    do_pop   = pop & ~empty & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one memory request at a time at pc_in,
// buffers {pc, instr} responses for decode, and drops stale responses after a flush.
//
// Handshakes: imem_req/imem_gnt transfer a request in any cycle both are high;
// imem_rvalid marks the single response to the outstanding request;
// id_valid/id_ready transfer the head entry in any cycle both are high, and
// id_pc/id_instr hold steady while id_valid is high and id_ready is low.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_en,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  input  logic            id_ready,
  output fetch_state_e    dbg_state
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            push, pop;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [2*XLEN-1:0] fifo_rdata;

  // Requests only from IDLE with room in the buffer; rst_n gating keeps
  // the outputs quiet while reset is held.
  assign imem_req  = rst_n & (state_q == ST_IDLE) & (fifo_count < CW'(DEPTH)) & ~flush;
  assign imem_addr = pc_in;
  assign pc_en     = rst_n & (flush | (imem_req & imem_gnt));
  assign id_valid  = ~fifo_empty;
  assign id_pc     = fifo_rdata[2*XLEN-1:XLEN];
  assign id_instr  = fifo_rdata[XLEN-1:0];
  assign pop       = id_valid & id_ready;
  assign dbg_state = state_q;

  // Next-state logic: track the single outstanding request and decide push/drop.
  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    push     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (imem_req & imem_gnt) begin
          state_d  = ST_WAIT;
          req_pc_d = imem_addr;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_d = imem_rvalid ? ST_IDLE : ST_DROP;
        end else if (imem_rvalid) begin
          push    = ~fifo_full;
          state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (imem_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and captured request PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_fifo #(
    .W     (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({req_pc_q, imem_rdata}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small zero/random-wait memory responder.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam logic [XLEN-1:0] KEY = 32'h5A5A_0000;

  logic            clk;
  logic            rst_n;
  logic [XLEN-1:0] pc_in;
  logic            pc_en;
  logic            flush;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_instr;
  logic            id_ready;
  fetch_state_e    dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // responder / scoreboard state
  bit              pend;
  logic [XLEN-1:0] pend_addr;
  int              occ;
  int              fires;
  int              pops;
  logic [XLEN-1:0] exp_pc;

  fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_in       (pc_in),
    .pc_en       (pc_en),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_instr    (id_instr),
    .id_ready    (id_ready),
    .dbg_state   (dbg_state)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    flush       = 1'b0;
    id_ready    = 1'b0;
  endtask

  // One cycle of the memory responder: grant when g, return the pending
  // response when rv_en, consume with rdy; model PC counter and buffer occupancy.
  task automatic tick(input bit g, input bit rv_en, input bit rdy);
    logic            fire;
    logic [XLEN-1:0] pc_next;
    imem_gnt    = g;
    imem_rvalid = pend & rv_en;
    imem_rdata  = pend_addr ^ KEY;
    id_ready    = rdy;
    flush       = 1'b0;
    #1;
    if (pend) check("one_outstanding", imem_req, 1'b0);
    check("id_valid_occ", id_valid, (occ != 0));
    fire = imem_req & imem_gnt;
    check("pc_en_fire", pc_en, fire);
    if (id_valid && id_ready) begin
      check("pop_pc", id_pc, exp_pc);
      check("pop_instr", id_instr, exp_pc ^ KEY);
      exp_pc = exp_pc + 32'd4;
      occ--;
      pops++;
    end
    if (imem_rvalid) begin
      pend = 1'b0;
      occ++;
      check("occ_bound", (occ <= DEPTH), 1'b1);
    end
    if (fire) begin
      check("req_addr", imem_addr, pc_in);
      pend      = 1'b1;
      pend_addr = imem_addr;
      fires++;
    end
    pc_next = pc_en ? pc_in + 32'd4 : pc_in;
    @(posedge clk);
    #1;
    pc_in = pc_next;
  endtask

  task automatic model_reset(input logic [XLEN-1:0] start_pc);
    pend      = 1'b0;
    pend_addr = '0;
    occ       = 0;
    fires     = 0;
    pops      = 0;
    exp_pc    = start_pc;
    pc_in     = start_pc;
  endtask

  initial begin
    // ---- reset values (with flush/gnt asserted to show they are masked)
    rst_n = 1'b0;
    quiet_inputs();
    pc_in    = '0;
    imem_gnt = 1'b1;
    flush    = 1'b1;
    #1;
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_pc_en", pc_en, 1'b0);
    check("rst_id_valid", id_valid, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    cyc();
    cyc();
    quiet_inputs();
    rst_n = 1'b1;

    // ---- single fetch: gnt at 0x0, rvalid next cycle, id_valid the cycle after
    pc_in    = 32'h0;
    imem_gnt = 1'b1;
    id_ready = 1'b1;
    #1;
    check("f1_req", imem_req, 1'b1);
    check("f1_addr", imem_addr, 32'h0);
    check("f1_pc_en", pc_en, 1'b1);
    cyc();
    pc_in       = 32'h4;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    #1;
    check("f1_wait", dbg_state, ST_WAIT);
    check("f1_pc_en_once", pc_en, 1'b0);
    check("f1_no_req_in_wait", imem_req, 1'b0);
    check("f1_not_valid_yet", id_valid, 1'b0);
    cyc();
    imem_rvalid = 1'b0;
    #1;
    check("f1_valid", id_valid, 1'b1);
    check("f1_id_pc", id_pc, 32'h0);
    check("f1_id_instr", id_instr, 32'h0050_0093);
    check("f1_idle", dbg_state, ST_IDLE);
    check("f1_pc_en_low", pc_en, 1'b0);
    cyc();
    #1;
    check("f1_popped", id_valid, 1'b0);

    // ---- backpressure: 4 zero-wait fetches offered, only 2 fit
    quiet_inputs();
    model_reset(32'h0);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b0);
    #1;
    check("bp_fires", fires, 2);
    check("bp_req_low", imem_req, 1'b0);
    check("bp_head_pc", id_pc, 32'h0);
    check("bp_head_instr", id_instr, 32'h5A5A_0000);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1);
    check("bp_pops", pops, 2);
    check("bp_last_exp", exp_pc, 32'h8);
    check("bp_empty", id_valid, 1'b0);

    // ---- flush while WAIT, late response dropped, refetch from redirect
    quiet_inputs();
    pc_in    = 32'h20;
    imem_gnt = 1'b1;
    id_ready = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    pc_in    = 32'h24;
    flush    = 1'b1;
    #1;
    check("fl_state_wait", dbg_state, ST_WAIT);
    check("fl_pc_en", pc_en, 1'b1);
    check("fl_req_masked", imem_req, 1'b0);
    cyc();
    flush = 1'b0;
    pc_in = 32'h100;
    #1;
    check("fl_drop", dbg_state, ST_DROP);
    check("fl_valid0", id_valid, 1'b0);
    check("fl_req_drop", imem_req, 1'b0);
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    #1;
    check("fl_drop_kept", dbg_state, ST_DROP);
    cyc();
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b1;
    #1;
    check("fl_back_idle", dbg_state, ST_IDLE);
    check("fl_dropped", id_valid, 1'b0);
    check("fl_req", imem_req, 1'b1);
    check("fl_addr", imem_addr, 32'h100);
    cyc();
    imem_gnt    = 1'b0;
    pc_in       = 32'h104;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0013;
    cyc();
    imem_rvalid = 1'b0;
    #1;
    check("fl_new_valid", id_valid, 1'b1);
    check("fl_new_pc", id_pc, 32'h100);
    check("fl_new_instr", id_instr, 32'h0000_0013);
    cyc();
    #1;
    check("fl_new_popped", id_valid, 1'b0);

    // ---- flush and rvalid together with one entry buffered
    quiet_inputs();
    pc_in    = 32'h40;
    imem_gnt = 1'b1;
    cyc();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h11;
    pc_in       = 32'h44;
    cyc();
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b1;
    #1;
    check("fr_one_entry", id_valid, 1'b1);
    cyc();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h22;
    flush       = 1'b1;
    pc_in       = 32'h48;
    #1;
    check("fr_state_wait", dbg_state, ST_WAIT);
    check("fr_pc_en", pc_en, 1'b1);
    cyc();
    imem_rvalid = 1'b0;
    flush       = 1'b0;
    #1;
    check("fr_empty", id_valid, 1'b0);
    check("fr_idle", dbg_state, ST_IDLE);
    check("fr_req", imem_req, 1'b1);

    // ---- random wait states with a full buffer and mostly-ready decode
    quiet_inputs();
    model_reset(32'h200);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 1'b0);
    check("rnd_full_fires", fires, 2);
    for (int i = 0; i < 200; i++)
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
    for (int i = 0; i < 30; i++) begin
      if (occ == 0 && !pend) break;
      tick(1'b0, 1'b1, 1'b1);
    end
    check("rnd_drained", (occ == 0 && !pend), 1'b1);
    check("rnd_pops_eq_fires", pops, fires);
    check("rnd_empty", id_valid, 1'b0);

    // ---- reset asserted mid-request, stale response afterwards
    quiet_inputs();
    pc_in    = 32'h80;
    imem_gnt = 1'b1;
    cyc();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h77;
    pc_in       = 32'h84;
    cyc();
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    pc_in    = 32'h88;
    #1;
    check("ar_wait", dbg_state, ST_WAIT);
    check("ar_has_entry", id_valid, 1'b1);
    #1;
    rst_n    = 1'b0;
    imem_gnt = 1'b1;
    flush    = 1'b1;
    #1;
    check("ar_state", dbg_state, ST_IDLE);
    check("ar_valid", id_valid, 1'b0);
    check("ar_req", imem_req, 1'b0);
    check("ar_pc_en", pc_en, 1'b0);
    cyc();
    cyc();
    quiet_inputs();
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0BAD;
    #1;
    check("ar_stale_idle", dbg_state, ST_IDLE);
    cyc();
    imem_rvalid = 1'b0;
    #1;
    check("ar_stale_ignored", id_valid, 1'b0);
    check("ar_stale_state", dbg_state, ST_IDLE);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
